// File: rtl/bcd_pkg.sv
// Shared widths and the packed BCD result type for the binary-to-BCD converter.
package bcd_pkg;

    localparam int BIN_W   = 8;
    localparam int BCD_W   = 10;
    localparam int DIGIT_W = 4;

    typedef struct packed {
        logic [1:0]         hund;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// 8-bit binary to 3-digit packed BCD: unrolled double-dabble feeding a
// result register, one conversion per cycle with single-cycle latency.
module bin_to_bcd
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] BIN,
    input  logic             bin_valid,
    output logic [BCD_W-1:0] BCD,
    output logic             bcd_valid
);

    localparam int SCRATCH_W = BCD_W + BIN_W;

    // Scratch layout: {hund[1:0], tens[3:0], ones[3:0], bin[7:0]}
    logic [SCRATCH_W-1:0] stage [0:BIN_W];
    bcd_t                 result;
    bcd_t                 bcd_q;
    logic                 valid_q;

    assign stage[0] = {{BCD_W{1'b0}}, BIN};

    genvar i;
    generate
        for (i = 0; i < BIN_W; i++) begin : g_dabble
            logic [DIGIT_W-1:0] tens_adj;
            logic [DIGIT_W-1:0] ones_adj;

            bcd_add3 u_tens (
                .digit    (stage[i][15:12]),
                .adjusted (tens_adj)
            );

            bcd_add3 u_ones (
                .digit    (stage[i][11:8]),
                .adjusted (ones_adj)
            );

            // Hundreds never reaches 5, so it shifts through uncorrected;
            // its top bit is always zero before a shift and drops off.
            assign stage[i+1] = {stage[i][16], tens_adj, ones_adj,
                                 stage[i][7:0], 1'b0};
        end
    endgenerate

    assign result = stage[BIN_W][17:8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bin_valid;
            if (bin_valid) begin
                bcd_q <= result;
            end
        end
    end

    assign BCD       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd against a decimal arithmetic model.
module tb_bin_to_bcd;

    logic       clk;
    logic       rst_n;
    logic [7:0] bin_r;
    logic       bin_valid;
    logic [9:0] bcd;
    logic       bcd_valid;

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_bcd   = 10'd0;
    logic       exp_valid = 1'b0;
    int         last_bin  = 0;

    bin_to_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BIN       (bin_r),
        .bin_valid (bin_valid),
        .BCD       (bcd),
        .bcd_valid (bcd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] dec(input int v);
        int h;
        int t;
        int o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        return {h[1:0], t[3:0], o[3:0]};
    endfunction

    // Advance one edge, update the reference model with what was sampled,
    // then check the per-cycle output invariants.
    task automatic tick();
        int d;
        @(posedge clk);
        if (!rst_n) begin
            exp_bcd   = 10'd0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = bin_valid;
            if (bin_valid) begin
                exp_bcd  = dec(int'(bin_r));
                last_bin = int'(bin_r);
            end
        end
        #1;
        total++;
        if (bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9 || bcd[9:8] > 2'd2) begin
            bad++;
            $display("FAIL invariant_digits: got %h, each digit must be decimal", bcd);
        end
        if (bcd_valid === 1'b1) begin
            d = 100 * int'(bcd[9:8]) + 10 * int'(bcd[7:4]) + int'(bcd[3:0]);
            total++;
            if (d != last_bin) begin
                bad++;
                $display("FAIL invariant_value: decoded %0d, required %0d", d, last_bin);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bin_r     = 8'd77;
        bin_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bcd !== 10'h000 || bcd_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset: got bcd=%h valid=%b, required bcd=000 valid=0", bcd, bcd_valid);
            end
        end
        rst_n     = 1'b1;
        bin_valid = 1'b0;
        tick();
    endtask

    task automatic test_boundaries();
        logic [7:0] vals [8];
        logic [9:0] gold [8];
        vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200, 8'd255};
        gold = '{10'h000, 10'h009, 10'h010, 10'h099, 10'h100, 10'h199, 10'h200, 10'h255};
        for (int k = 0; k < 8; k++) begin
            bin_r     = vals[k];
            bin_valid = 1'b1;
            tick();
            total++;
            if (bcd !== gold[k] || bcd_valid !== 1'b1) begin
                bad++;
                $display("FAIL boundary_%0d: got bcd=%h valid=%b, required bcd=%h valid=1",
                         vals[k], bcd, bcd_valid, gold[k]);
            end
            bin_valid = 1'b0;
            tick();
            total++;
            if (bcd_valid !== 1'b0) begin
                bad++;
                $display("FAIL boundary_idle_%0d: got valid=%b, required 0", vals[k], bcd_valid);
            end
        end
    endtask

    task automatic test_sweep();
        bin_valid = 1'b1;
        for (int k = 0; k <= 256; k++) begin
            bin_r = 8'(k);
            tick();
            total++;
            if (bcd !== dec(k % 256) || bcd_valid !== 1'b1) begin
                bad++;
                $display("FAIL sweep_%0d: got bcd=%h valid=%b, required bcd=%h valid=1",
                         k, bcd, bcd_valid, dec(k % 256));
            end
        end
        total++;
        if (bcd !== 10'h000) begin
            bad++;
            $display("FAIL sweep_wrap: got %h, required 000", bcd);
        end
        bin_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        bin_r     = 8'd123;
        bin_valid = 1'b1;
        tick();
        total++;
        if (bcd !== 10'h123 || bcd_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_load: got bcd=%h valid=%b, required bcd=123 valid=1", bcd, bcd_valid);
        end
        bin_r     = 8'd45;
        bin_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (bcd !== 10'h123 || bcd_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: got bcd=%h valid=%b, required bcd=123 valid=0",
                         k, bcd, bcd_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        bin_r     = 8'd250;
        bin_valid = 1'b1;
        tick();
        total++;
        if (bcd !== 10'h250 || bcd_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre: got bcd=%h valid=%b, required bcd=250 valid=1", bcd, bcd_valid);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (bcd !== 10'h000 || bcd_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_reset: got bcd=%h valid=%b, required bcd=000 valid=0", bcd, bcd_valid);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bcd !== 10'h250 || bcd_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_resume: got bcd=%h valid=%b, required bcd=250 valid=1", bcd, bcd_valid);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            bin_r     = 8'($urandom_range(255, 0));
            bin_valid = ($urandom_range(3, 0) != 0);
            tick();
            total++;
            if (bcd !== exp_bcd || bcd_valid !== exp_valid) begin
                bad++;
                $display("FAIL random_%0d: got bcd=%h valid=%b, required bcd=%h valid=%b",
                         k, bcd, bcd_valid, exp_bcd, exp_valid);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bin_r     = 8'd0;
        bin_valid = 1'b0;
        test_reset();
        test_boundaries();
        test_sweep();
        test_hold();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
